pdm_nco_gen2: RTL

Parametrised numerically controlled oscillator with a first-order sigma-delta PDM output.
- Phase accumulator with glitch-free frequency updates: a new word is applied only at a phase wrap.
- Selectable waveform (saw, square, triangle, midscale), phase sync and a wrap strobe.
- Sits between the user-IO pins and an external RC low-pass filter; the single-bit stream is the analogue output.

---
 rtl/nco_pkg.sv | 17 +
 rtl/pdm_mod1.sv | 28 ++
 rtl/pdm_nco_gen2.sv | 138 +++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared constants for the PDM NCO: waveform mode encodings and dither LFSR setup.
package nco_pkg;

  localparam logic [1:0] MODE_SAW = 2'b00;
  localparam logic [1:0] MODE_SQR = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;
  localparam logic [1:0] MODE_MID = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pdm_mod1.sv
// First-order sigma-delta modulator: accumulates amplitude into an error register and
// emits the carry as a registered single-bit stream.
module pdm_mod1 #(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [OUT_W-1:0] amp,
  output logic             pdm_out
);

  logic [OUT_W-1:0] err_q;
  logic [OUT_W:0]   sum;

  assign sum = {1'b0, err_q} + {1'b0, amp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q   <= '0;
      pdm_out <= 1'b0;
    end else if (ena) begin
      err_q   <= sum[OUT_W-1:0];
      pdm_out <= sum[OUT_W];
    end
  end

endmodule

// File: rtl/pdm_nco_gen2.sv
// Phase-accumulator NCO with wrap-synchronised frequency updates feeding a PDM modulator.
// Define PDM_NCO_DITHER_EN to add LFSR dither on the amplitude LSB.
module pdm_nco_gen2 #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned FW_W  = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [FW_W-1:0] freq_in,
  input  logic            freq_load,
  input  logic [1:0]      mode,
  input  logic            phase_sync,
  output logic            pdm_out,
  output logic            wrap_pulse,
  output logic            freq_busy
);

  import nco_pkg::*;

  if (ACC_W < OUT_W) begin : g_bad_acc_w
    $error("ACC_W must be >= OUT_W");
  end
  if (FW_W > ACC_W) begin : g_bad_fw_w
    $error("FW_W must be <= ACC_W");
  end
  if (OUT_W < 2) begin : g_bad_out_w
    $error("OUT_W must be >= 2");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW_W-1:0]  active_freq_q, active_freq_d;
  logic [FW_W-1:0]  pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             wrap_q, wrap_d;

  logic [ACC_W:0]   sum;
  logic             carry;

  assign sum   = {1'b0, acc_q} + (ACC_W + 1)'(active_freq_q);
  assign carry = sum[ACC_W];

  always_comb begin
    acc_d         = acc_q;
    wrap_d        = wrap_q;
    active_freq_d = active_freq_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;

    if (phase_sync) begin
      acc_d  = '0;
      wrap_d = 1'b0;
    end else begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = carry;
    end

    // Apply a word directly when changing it cannot produce a short or glitched period.
    if (freq_load) begin
      if ((active_freq_q == '0) || carry || phase_sync) begin
        active_freq_d = freq_in;
        pend_valid_d  = 1'b0;
      end else begin
        pend_d       = freq_in;
        pend_valid_d = 1'b1;
      end
    end else if (pend_valid_q && (carry || phase_sync)) begin
      active_freq_d = pend_q;
      pend_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      active_freq_q <= '0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      wrap_q        <= 1'b0;
    end else if (ena) begin
      acc_q         <= acc_d;
      active_freq_q <= active_freq_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;
  assign freq_busy  = pend_valid_q;

  logic [OUT_W-1:0] ph;
  logic [OUT_W-1:0] tri_base;
  logic [OUT_W-1:0] amp;
  logic [OUT_W-1:0] amp_d;

  assign ph       = acc_q[ACC_W-1 -: OUT_W];
  assign tri_base = {ph[OUT_W-2:0], 1'b0};

  always_comb begin
    amp = '0;
    case (mode)
      MODE_SAW: amp = ph;
      MODE_SQR: amp = {OUT_W{ph[OUT_W-1]}};
      MODE_TRI: amp = ph[OUT_W-1] ? ~tri_base : tri_base;
      MODE_MID: amp[OUT_W-1] = 1'b1;
      default:  amp = '0;
    endcase
  end

`ifdef PDM_NCO_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (ena) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign amp_d = {amp[OUT_W-1:1], amp[0] ^ lfsr_q[0]};
`else
  assign amp_d = amp;
`endif

  pdm_mod1 #(
    .OUT_W (OUT_W)
  ) u_pdm_mod1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .amp     (amp_d),
    .pdm_out (pdm_out)
  );

endmodule
